fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (legal range 2..65535).
REQ-002 The block SHALL have port clock, input, 1, system clock; all logic rising-edge.
REQ-003 The block SHALL have port sclr_n, input, 1, synchronous active-low reset sampled on rising clock.
REQ-004 The block SHALL have port empty, input, 1, upstream FIFO empty flag.
REQ-005 The block SHALL have port q, input, 8, upstream FIFO read data, valid the cycle after rdreq.
REQ-006 The block SHALL have port rdreq, output, 1, FIFO read request, one-cycle pulse per byte.
REQ-007 The block SHALL have port txd, output, 1, UART serial line, idle high.
REQ-008 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 The block SHALL have port tx_done, output, 1, one-cycle pulse on the last cycle of each stop bit.

Function
REQ-010 The block SHALL implement states IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-011 IDLE SHALL go to FETCH on the next edge when empty=0; otherwise it SHALL stay in IDLE with txd=1.
REQ-012 rdreq SHALL be 1 only during the single FETCH cycle; FETCH SHALL always go to LOAD.
REQ-013 LOAD SHALL capture q into an 8-bit shift register and go to START.
REQ-014 START SHALL drive txd=0 for exactly CLKS_PER_BIT cycles.
REQ-015 DATA SHALL drive the 8 bits LSB first, each for exactly CLKS_PER_BIT cycles, using a 3-bit bit index that counts 0..7.
REQ-016 DATA SHALL go to PARITY when PARITY_EN is defined, and to STOP otherwise.
REQ-017 PARITY SHALL drive the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-018 STOP SHALL drive txd=1 for CLKS_PER_BIT cycles, pulse tx_done in its last cycle, and then return to IDLE.
REQ-019 The bit-period counter SHALL be 16 bits wide, SHALL reset to 0 at every bit boundary, and SHALL never wrap mid-bit.
REQ-020 Between consecutive frames with data waiting, there SHALL be exactly 3 cycles of txd=1 (IDLE, FETCH, LOAD) after the stop bit.
REQ-021 empty SHALL be ignored outside IDLE, and at most one rdreq SHALL be issued per frame; the FIFO is never over-read.
REQ-022 If empty rises during a frame, the frame in progress SHALL complete unchanged.
REQ-023 txd, rdreq, busy and tx_done SHALL be driven from registers or from decoded state only, with no combinational path from q or empty to txd.

Reset
REQ-024 When sclr_n=0 on a rising edge, the block SHALL set state=IDLE, txd=1, rdreq=0, busy=0, tx_done=0, and clear all counters and the shift register.
REQ-025 A reset asserted mid-frame SHALL abort the frame, discard the byte, and set txd=1 on the cycle after the reset edge.
REQ-026 A reset coincident with FETCH SHALL drop that rdreq pulse in the following cycle; the byte already popped is lost.

Configuration
REQ-027 When macro PARITY_EN is defined, each frame SHALL be 11 bits (start, 8 data, even parity, stop) and the PARITY state SHALL be present.
REQ-028 When PARITY_EN is undefined, each frame SHALL be 10 bits (8N1) and the PARITY state and its logic SHALL not be compiled.

Verification (CLKS_PER_BIT=4, FIFO model with 1-cycle read latency)
REQ-029 The bench SHALL send one byte 0x56 with PARITY_EN off and require 1 rdreq pulse, txd bit sequence 0,0,1,1,0,1,0,1,0,1 with each bit 4 cycles, 40-cycle frame, and one tx_done pulse.
REQ-030 The bench SHALL preload bytes 0x56, 0xAA, 0xFF, 0xAA and require 4 rdreq pulses, 4 correct frames, and exactly 3 idle-high cycles between frames.
REQ-031 The bench SHALL hold empty=1 for 200 cycles and require rdreq=0, txd=1 and busy=0 throughout.
REQ-032 The bench SHALL assert sclr_n=0 for 1 cycle at bit 3 of a 0xAA frame and require txd=1 and busy=0 the next cycle, then a correct fresh frame for the next FIFO byte.
REQ-033 The bench SHALL send byte 0x07 with PARITY_EN defined and require parity bit 1, a 44-cycle frame, and tx_done at cycle 44.
REQ-034 The bench SHALL send byte 0x56 with PARITY_EN defined and require parity bit 0.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops one byte per frame from a 1-cycle-latency FIFO and serialises it as a UART frame.
// Default build is 8N1; define PARITY_EN for 8E1 (even parity bit between data and stop).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       sclr_n,
  input  logic       empty,
  input  logic [7:0] q,
  output logic       rdreq,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
`ifdef PARITY_EN
  logic        parity_q, parity_d;
`endif
  logic        bit_end;
  logic        in_bit;

  assign bit_end = (cnt_q == LAST_CNT);

  always_comb begin
    in_bit = 1'b0;
    case (state_q)
      START, DATA, STOP: in_bit = 1'b1;
`ifdef PARITY_EN
      PARITY:            in_bit = 1'b1;
`endif
      default:           in_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef PARITY_EN
    parity_d  = parity_q;
`endif

    // The bit timer runs only inside a serial bit and restarts at every boundary.
    if (in_bit) begin
      cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
    end else begin
      cnt_d = 16'd0;
    end

    case (state_q)
      IDLE: begin
        bit_idx_d = 3'd0;
        if (!empty) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = q;
`ifdef PARITY_EN
        parity_d = ^q;
`endif
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
`ifdef PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Outputs decode only registered state, so q/empty never reach txd combinationally.
  always_comb begin
    rdreq   = (state_q == FETCH);
    busy    = (state_q != IDLE);
    tx_done = (state_q == STOP) && bit_end;
    case (state_q)
      START:   txd = 1'b0;
      DATA:    txd = shift_q[0];
`ifdef PARITY_EN
      PARITY:  txd = parity_q;
`endif
      default: txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds bytes, a UART receiver monitor
// rebuilds each frame from txd and checks it against the expected byte queue.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clock  = 1'b0;
  logic       sclr_n = 1'b0;
  logic       empty  = 1'b1;
  logic [7:0] q      = 8'h00;
  logic       rdreq;
  logic       txd;
  logic       busy;
  logic       tx_done;

  int tests    = 0;
  int fails    = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;
  logic rd_seen = 1'b0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  logic samples [FRAME_CYC];
  logic dones   [FRAME_CYC];
  bit   in_frame  = 1'b0;
  int   fcyc      = 0;
  bit   gap_valid = 1'b0;
  int   gap_cnt   = 0;

  always #5 clock = ~clock;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock   (clock),
    .sclr_n  (sclr_n),
    .empty   (empty),
    .q       (q),
    .rdreq   (rdreq),
    .txd     (txd),
    .busy    (busy),
    .tx_done (tx_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference frame: bit index 0 is start, 1..8 data LSB first, optional even parity, then stop.
  function automatic logic expBit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic finishFrame();
    logic [7:0] exp_b;
    logic [7:0] act_b;
    int bad;
    int ndone;
    int lastd;
    if (exp_q.size() == 0) begin
      checkOutput("frame_expected", 32'(exp_q.size()), 32'd1);
      return;
    end
    exp_b = exp_q.pop_front();
    bad = 0;
    for (int i = 0; i < FRAME_CYC; i++)
      if (samples[i] !== expBit(exp_b, i / CPB)) bad++;
    act_b = 8'h00;
    for (int i = 0; i < 8; i++) act_b[i] = samples[(i + 1) * CPB + CPB / 2];
    checkOutput("frame_byte", 32'(act_b), 32'(exp_b));
    checkOutput("frame_bad_cycles", bad, 0);
`ifdef PARITY_EN
    checkOutput("parity_bit", 32'(samples[9 * CPB + CPB / 2]), 32'(^exp_b));
`endif
    ndone = 0;
    lastd = -1;
    for (int i = 0; i < FRAME_CYC; i++)
      if (dones[i] === 1'b1) begin
        ndone++;
        lastd = i;
      end
    checkOutput("tx_done_count", ndone, 1);
    checkOutput("tx_done_cycle", lastd + 1, FRAME_CYC);
  endtask

  // FIFO model: a byte requested in one cycle appears on q in the next.
  always @(posedge clock) begin
    if (rd_seen) begin
      checkOutput("rdreq_with_data", 32'(fifo_q.size() > 0), 32'd1);
      if (fifo_q.size() > 0) q <= fifo_q.pop_front();
    end
    empty <= (fifo_q.size() == 0);
  end

  // Receiver monitor sampling mid-cycle.
  always @(negedge clock) begin
    rd_seen = rdreq;
    if (rdreq === 1'b1) rd_cnt++;
    if (tx_done === 1'b1) done_cnt++;
    if (!sclr_n) begin
      in_frame  = 1'b0;
      gap_valid = 1'b0;
      gap_cnt   = 0;
    end else begin
      if (!in_frame) begin
        if (txd === 1'b0) begin
          if (gap_valid) checkOutput("idle_gap", gap_cnt, 3);
          gap_valid = 1'b0;
          in_frame  = 1'b1;
          fcyc      = 0;
        end else begin
          gap_cnt++;
        end
      end
      if (in_frame) begin
        samples[fcyc] = txd;
        dones[fcyc]   = tx_done;
        checkOutput("busy_in_frame", 32'(busy), 32'd1);
        fcyc++;
        if (fcyc == FRAME_CYC) begin
          finishFrame();
          in_frame  = 1'b0;
          gap_cnt   = 0;
          gap_valid = (fifo_q.size() != 0);
        end
      end
    end
  end

  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !(exp_q.size() == 0 && fifo_q.size() == 0 && busy === 1'b0 && !in_frame)) begin
      @(negedge clock);
      n++;
    end
    checkOutput({name, "_timeout"}, 32'(n >= budget), 32'd0);
    tick(1);
  endtask

  initial begin
    #500000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int r0;
    int d0;
    int n;
    int nb;
    logic [7:0] burst [4];
    burst[0] = 8'h56;
    burst[1] = 8'hAA;
    burst[2] = 8'hFF;
    burst[3] = 8'hAA;

    sclr_n = 1'b0;
    tick(3);
    @(negedge clock);
    checkOutput("reset_txd", 32'(txd), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rdreq", 32'(rdreq), 32'd0);
    checkOutput("reset_tx_done", 32'(tx_done), 32'd0);
    tick(1);
    sclr_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      checkOutput("idle_rdreq_txd_busy", 32'({rdreq, txd, busy}), 32'b010);
    end
    tick(1);

    $display("[TB] single byte 0x56");
    r0 = rd_cnt;
    d0 = done_cnt;
    applyStimulus(8'h56);
    waitIdle("single", 200);
    checkOutput("single_rdreq_pulses", rd_cnt - r0, 1);
    checkOutput("single_tx_done_pulses", done_cnt - d0, 1);

    $display("[TB] back-to-back burst");
    r0 = rd_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) applyStimulus(burst[i]);
    waitIdle("burst", 400);
    checkOutput("burst_rdreq_pulses", rd_cnt - r0, 4);
    checkOutput("burst_tx_done_pulses", done_cnt - d0, 4);

    $display("[TB] reset during data bit 3");
    r0 = rd_cnt;
    d0 = done_cnt;
    applyStimulus(8'hAA);
    applyStimulus(8'h3C);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (txd !== 1'b0 && n < 100);
    checkOutput("abort_start_seen", 32'(txd), 32'd0);
    repeat (17) @(posedge clock);
    #1;
    sclr_n = 1'b0;
    void'(exp_q.pop_front());
    tick(1);
    sclr_n = 1'b1;
    @(negedge clock);
    checkOutput("abort_txd", 32'(txd), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    waitIdle("abort", 200);
    checkOutput("abort_rdreq_pulses", rd_cnt - r0, 2);
    checkOutput("abort_tx_done_pulses", done_cnt - d0, 1);

    $display("[TB] parity bytes 0x07 and 0x56");
    applyStimulus(8'h07);
    waitIdle("byte07", 200);
    applyStimulus(8'h56);
    waitIdle("byte56", 200);

    $display("[TB] random bursts");
    for (int k = 0; k < 8; k++) begin
      r0 = rd_cnt;
      nb = int'($urandom_range(1, 3));
      for (int j = 0; j < nb; j++) applyStimulus(8'($urandom));
      waitIdle("random", 600);
      checkOutput("random_rdreq_pulses", rd_cnt - r0, nb);
      tick(int'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
